// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock FIFO. It buffers a word stream between a producer
//   and a consumer in the same clock domain. It reports a live occupancy count,
//   full/empty and programmable almost-full/almost-empty flags, and sticky
//   overflow/underflow error flags.
//
// Parameters
//   FIFO_DEPTH  number of entries (power of 2, >= 2)
//   FIFO_WIDTH  data width in bits (>= 1)
//   AFULL_LVL   fifo_afull  is set when count >= AFULL_LVL  (1..FIFO_DEPTH)
//   AEMPTY_LVL  fifo_aempty is set when count <= AEMPTY_LVL (0..FIFO_DEPTH-1)
//
// Ports
//   clk            clock, all state changes on posedge
//   rst_           synchronous active-low reset (overrides all requests)
//   fifo_write     write request
//   fifo_data_in   write data
//   fifo_read      read request
//   fifo_data_out  read data, registered, valid one cycle after an accepted read
//   fifo_full      count == FIFO_DEPTH
//   fifo_empty     count == 0
//   fifo_afull     count >= AFULL_LVL
//   fifo_aempty    count <= AEMPTY_LVL
//   fifo_cnt       current occupancy, 0..FIFO_DEPTH
//   fifo_ovf       sticky: a write arrived while full and was dropped
//   fifo_udf       sticky: a read arrived while empty
//   err_clr        clears fifo_ovf / fifo_udf (a new error in the same cycle wins)
// -----------------------------------------------------------------------------
module fifo_sync_param #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 8,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                          clk,
  input  logic                          rst_,
  input  logic                          fifo_write,
  input  logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_read,
  output logic [FIFO_WIDTH-1:0]         fifo_data_out,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_afull,
  output logic                          fifo_aempty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          fifo_ovf,
  output logic                          fifo_udf,
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LVL);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt_nxt;

  logic wr_accept;
  logic rd_accept;
  logic ovf_set;
  logic udf_set;

  // Flags decode straight from the registered count so they never lag it.
  assign fifo_full   = (fifo_cnt == DEPTH_C);
  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_afull  = (fifo_cnt >= AFULL_C);
  assign fifo_aempty = (fifo_cnt <= AEMPTY_C);

  // A read while full frees a slot in the same cycle, so a simultaneous write
  // is still accepted. A read while empty is always ignored; there is no
  // fall-through path from fifo_data_in to fifo_data_out.
  assign wr_accept = fifo_write && (!fifo_full || fifo_read);
  assign rd_accept = fifo_read && !fifo_empty;
  assign ovf_set   = fifo_write && fifo_full && !fifo_read;
  assign udf_set   = fifo_read && fifo_empty;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    cnt_nxt = fifo_cnt;
    unique case ({wr_accept, rd_accept})
      2'b10:   cnt_nxt = fifo_cnt + CNT_W'(1);
      2'b01:   cnt_nxt = fifo_cnt - CNT_W'(1);
      default: cnt_nxt = fifo_cnt;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the pre-edge values of the others (e.g. the read of
  // mem[rd_ptr] sees the old word when a write to the same slot coincides).
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      fifo_data_out <= '0;
      fifo_ovf      <= 1'b0;
      fifo_udf      <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_accept) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        fifo_data_out <= mem[rd_ptr];
      end
      fifo_cnt <= cnt_nxt;

      // Set has priority over clear so a fresh error is never lost.
      if (ovf_set)      fifo_ovf <= 1'b1;
      else if (err_clr) fifo_ovf <= 1'b0;

      if (udf_set)      fifo_udf <= 1'b1;
      else if (err_clr) fifo_udf <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable once
  // the pointers and count are cleared, and leaving it unreset keeps it
  // mappable onto RAM.
  always_ff @(posedge clk) begin
    if (rst_ && wr_accept) mem[wr_ptr] <= fifo_data_in;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  localparam int DEPTH  = 16;
  localparam int WIDTH  = 8;
  localparam int AFULL  = 12;
  localparam int AEMPTY = 2;

  logic             clk = 1'b0;
  logic             rst_ = 1'b0;
  logic             fifo_write = 1'b0;
  logic [WIDTH-1:0] fifo_data_in = '0;
  logic             fifo_read = 1'b0;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_full, fifo_empty, fifo_afull, fifo_aempty;
  logic [4:0]       fifo_cnt;
  logic             fifo_ovf, fifo_udf;
  logic             err_clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  fifo_sync_param #(
    .FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)
  ) dut (
    .clk(clk), .rst_(rst_),
    .fifo_write(fifo_write), .fifo_data_in(fifo_data_in),
    .fifo_read(fifo_read), .fifo_data_out(fifo_data_out),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_afull(fifo_afull), .fifo_aempty(fifo_aempty),
    .fifo_cnt(fifo_cnt), .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the observable registers.
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout = '0;
  logic             m_ovf = 1'b0;
  logic             m_udf = 1'b0;

  task automatic model_step(input logic r_n, w, r, clr, input logic [WIDTH-1:0] d);
    bit was_full, was_empty;
    if (!r_n) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (w && was_full && !r) m_ovf = 1'b1;
      if (r && was_empty)      m_udf = 1'b1;
      if (r && !was_empty)     m_dout = q.pop_front();
      if (w && (!was_full || r)) q.push_back(d);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle: inputs set here, posedge, model update, sample 1 ns later.
  task automatic cycle(input logic r_n, w, r, clr, input logic [WIDTH-1:0] d);
    rst_ = r_n; fifo_write = w; fifo_read = r; err_clr = clr; fifo_data_in = d;
    @(posedge clk);
    model_step(r_n, w, r, clr, d);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    check({tag, ".cnt"},    32'(fifo_cnt),    32'(n));
    check({tag, ".full"},   32'(fifo_full),   32'(n == DEPTH));
    check({tag, ".empty"},  32'(fifo_empty),  32'(n == 0));
    check({tag, ".afull"},  32'(fifo_afull),  32'(n >= AFULL));
    check({tag, ".aempty"}, 32'(fifo_aempty), 32'(n <= AEMPTY));
    check({tag, ".dout"},   32'(fifo_data_out), 32'(m_dout));
    check({tag, ".ovf"},    32'(fifo_ovf),    32'(m_ovf));
    check({tag, ".udf"},    32'(fifo_udf),    32'(m_udf));
  endtask

  typedef struct {
    logic             rst_n, w, r, clr;
    logic [WIDTH-1:0] din;
    int               exp_cnt;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_ovf, exp_udf;
  } vec_t;

  vec_t vecs[11];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "timeout");
  end

  initial begin : main
    // ---------------- table-driven vectors ----------------
    //                rst w  r  clr din    cnt dout   ovf udf
    vecs[0]  = '{1'b0,1'b1,1'b1,1'b0,8'h11, 0, 8'h00, 1'b0,1'b0}; // reset wins over W/R
    vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,8'h22, 0, 8'h00, 1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,8'hA1, 1, 8'h00, 1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,8'hB2, 2, 8'h00, 1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,8'h00, 1, 8'hA1, 1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,8'hC3, 1, 8'hB2, 1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,8'h00, 0, 8'hC3, 1'b0,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b0,8'h00, 0, 8'hC3, 1'b0,1'b1}; // underflow
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,8'h00, 0, 8'hC3, 1'b0,1'b0}; // err_clr
    vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,8'h5A, 1, 8'hC3, 1'b0,1'b1}; // empty W+R, set beats clr
    vecs[10] = '{1'b1,1'b0,1'b1,1'b0,8'h00, 0, 8'h5A, 1'b0,1'b1};

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(vecs[i].rst_n, vecs[i].w, vecs[i].r, vecs[i].clr, vecs[i].din);
      check({t, ".cnt"},    32'(fifo_cnt),      32'(vecs[i].exp_cnt));
      check({t, ".dout"},   32'(fifo_data_out), 32'(vecs[i].exp_dout));
      check({t, ".empty"},  32'(fifo_empty),    32'(vecs[i].exp_cnt == 0));
      check({t, ".full"},   32'(fifo_full),     32'(0));
      check({t, ".aempty"}, 32'(fifo_aempty),   32'(vecs[i].exp_cnt <= AEMPTY));
      check({t, ".ovf"},    32'(fifo_ovf),      32'(vecs[i].exp_ovf));
      check({t, ".udf"},    32'(fifo_udf),      32'(vecs[i].exp_udf));
    end

    // ---------------- fill / drain ----------------
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
      check($sformatf("fill%0d.cnt", i),   32'(fifo_cnt),   32'(i + 1));
      check($sformatf("fill%0d.afull", i), 32'(fifo_afull), 32'((i + 1) >= 12));
      check($sformatf("fill%0d.full", i),  32'(fifo_full),  32'((i + 1) == 16));
    end

    // Overflow: write dropped, count steady, sticky flag set then cleared.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
    check("ovf.cnt",  32'(fifo_cnt), 32'(16));
    check("ovf.flag", 32'(fifo_ovf), 32'(1));
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("ovf.sticky", 32'(fifo_ovf), 32'(1));
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    check("ovf.clr", 32'(fifo_ovf), 32'(0));

    // Full with simultaneous W+R for 20 cycles: count pinned, order kept across wrap.
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h77);
      check($sformatf("wr_rd%0d.cnt", k),  32'(fifo_cnt), 32'(16));
      check($sformatf("wr_rd%0d.ovf", k),  32'(fifo_ovf), 32'(0));
      check($sformatf("wr_rd%0d.dout", k), 32'(fifo_data_out), (k < 16) ? 32'(k) : 32'h77);
    end

    // Drain: only 0x77 remains; the dropped 0xAA must never appear.
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("drain%0d.dout", k), 32'(fifo_data_out), 32'h77);
    end
    check("drain.empty", 32'(fifo_empty), 32'(1));
    check("drain.cnt",   32'(fifo_cnt),   32'(0));

    // ---------------- reset mid-operation ----------------
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);            // underflow sets udf
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    check("mid.cnt7", 32'(fifo_cnt), 32'(7));
    check("mid.udf",  32'(fifo_udf), 32'(1));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);            // dout = 0x40, cnt = 6
    check("mid.dout", 32'(fifo_data_out), 32'h40);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
    check("rst.cnt",    32'(fifo_cnt),      32'(0));
    check("rst.empty",  32'(fifo_empty),    32'(1));
    check("rst.aempty", 32'(fifo_aempty),   32'(1));
    check("rst.afull",  32'(fifo_afull),    32'(0));
    check("rst.udf",    32'(fifo_udf),      32'(0));
    check("rst.ovf",    32'(fifo_ovf),      32'(0));
    check("rst.dout",   32'(fifo_data_out), 32'(0));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    check("rst.fresh_dout", 32'(fifo_data_out), 32'h3C);
    check_model("rst.model");

    // ---------------- randomized against the model ----------------
    for (int c = 0; c < 3000; c++) begin
      int pw;
      logic r_n, w, r, clr;
      pw  = ((c / 150) % 2 == 0) ? 80 : 25;         // alternate filling / draining bias
      r_n = ($urandom_range(499) != 0);
      w   = ($urandom_range(99) < pw);
      r   = ($urandom_range(99) < (105 - pw));
      clr = ($urandom_range(19) == 0);
      cycle(r_n, w, r, clr, 8'($urandom));
      check_model($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
